// File: rtl/dmem_copy_engine.sv
// dmem_copy_engine: byte-wide copy / fill initiator for the data memory.
// In copy mode it alternates READ and WRITE cycles, moving one byte per
// pair; in fill mode it writes the latched fill byte once per cycle.
// A mod-256 checksum of every written byte is kept for the caller.
module dmem_copy_engine (
    input  logic       Clk,
    input  logic       Clear,
    input  logic       Start,
    input  logic       Mode,
    input  logic [7:0] Src_Addr,
    input  logic [7:0] Dst_Addr,
    input  logic [7:0] Length,
    input  logic [7:0] Fill_Data,
    input  logic [7:0] Mem_Read_Data,
    output logic [7:0] Mem_Address,
    output logic       Mem_Read,
    output logic       Mem_Write,
    output logic [7:0] Mem_Write_Data,
    output logic       Busy,
    output logic       Done,
    output logic [7:0] Checksum
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t     state;
    state_t     next_state;

    logic [7:0] src_ptr;
    logic [7:0] dst_ptr;
    logic [7:0] count;
    logic [7:0] data_buf;
    logic [7:0] fill_r;
    logic       mode_r;
    logic [7:0] wr_data;

    // Byte presented on a write: the buffered read in copy mode, the fill byte otherwise.
    assign wr_data = mode_r ? fill_r : data_buf;

    // State register with synchronous active-low clear.
    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of block ordering.
        if (!Clear) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; count==1 in WRITE means this write is the last one.
    always_comb begin
        // NOTE: default assignment first so no path leaves next_state
        // unassigned, which would otherwise infer a latch.
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (Start) begin
                    if (Length == 8'd0) begin
                        next_state = ST_DONE;
                    end else if (!Mode) begin
                        next_state = ST_READ;
                    end else begin
                        next_state = ST_WRITE;
                    end
                end
            end
            ST_READ: begin
                next_state = ST_WRITE;
            end
            ST_WRITE: begin
                if (count == 8'd1) begin
                    next_state = ST_DONE;
                end else if (!mode_r) begin
                    next_state = ST_READ;
                end else begin
                    next_state = ST_WRITE;
                end
            end
            ST_DONE: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Output decode: address and data are forced to 0 unless their enable is high.
    always_comb begin
        Mem_Address    = 8'h00;
        Mem_Read       = 1'b0;
        Mem_Write      = 1'b0;
        Mem_Write_Data = 8'h00;
        Busy           = 1'b0;
        Done           = 1'b0;
        case (state)
            ST_READ: begin
                Mem_Read    = 1'b1;
                Mem_Address = src_ptr;
                Busy        = 1'b1;
            end
            ST_WRITE: begin
                Mem_Write      = 1'b1;
                Mem_Address    = dst_ptr;
                Mem_Write_Data = wr_data;
                Busy           = 1'b1;
            end
            ST_DONE: begin
                Done = 1'b1;
            end
            default: begin
                Busy = 1'b0;
            end
        endcase
    end

    // Datapath: latch the request in IDLE, advance pointers and checksum per byte.
    always_ff @(posedge Clk) begin
        if (!Clear) begin
            src_ptr  <= 8'h00;
            dst_ptr  <= 8'h00;
            count    <= 8'h00;
            data_buf <= 8'h00;
            fill_r   <= 8'h00;
            mode_r   <= 1'b0;
            Checksum <= 8'h00;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (Start) begin
                        mode_r   <= Mode;
                        fill_r   <= Fill_Data;
                        src_ptr  <= Src_Addr;
                        dst_ptr  <= Dst_Addr;
                        count    <= Length;
                        Checksum <= 8'h00;
                    end
                end
                ST_READ: begin
                    data_buf <= Mem_Read_Data;
                    src_ptr  <= src_ptr + 8'd1;
                end
                ST_WRITE: begin
                    Checksum <= Checksum + wr_data;
                    dst_ptr  <= dst_ptr + 8'd1;
                    count    <= count - 8'd1;
                end
                default: begin
                    count <= count;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_copy_engine.sv
// Self-checking bench for dmem_copy_engine. A behavioural memory answers the
// engine's port; a reference model predicts, per transfer, the cycle-by-cycle
// port activity, the final memory image and the checksum.
module tb_dmem_copy_engine;

    logic       Clk = 1'b0;
    logic       Clear;
    logic       Start;
    logic       Mode;
    logic [7:0] Src_Addr;
    logic [7:0] Dst_Addr;
    logic [7:0] Length;
    logic [7:0] Fill_Data;
    logic [7:0] Mem_Read_Data;
    logic [7:0] Mem_Address;
    logic       Mem_Read;
    logic       Mem_Write;
    logic [7:0] Mem_Write_Data;
    logic       Busy;
    logic       Done;
    logic [7:0] Checksum;

    int checks = 0;
    int errors = 0;

    bit [7:0]    mem     [256];
    bit [7:0]    exp_mem [256];
    logic [19:0] exp_q   [$];
    logic [7:0]  exp_sum;
    logic [19:0] obs;

    always #5 Clk = ~Clk;

    dmem_copy_engine dut (
        .Clk           (Clk),
        .Clear         (Clear),
        .Start         (Start),
        .Mode          (Mode),
        .Src_Addr      (Src_Addr),
        .Dst_Addr      (Dst_Addr),
        .Length        (Length),
        .Fill_Data     (Fill_Data),
        .Mem_Read_Data (Mem_Read_Data),
        .Mem_Address   (Mem_Address),
        .Mem_Read      (Mem_Read),
        .Mem_Write     (Mem_Write),
        .Mem_Write_Data(Mem_Write_Data),
        .Busy          (Busy),
        .Done          (Done),
        .Checksum      (Checksum)
    );

    // Behavioural data memory: combinational read, write on the rising edge.
    assign Mem_Read_Data = Mem_Read ? mem[Mem_Address] : 8'h00;
    always @(posedge Clk) begin
        if (Mem_Write) mem[Mem_Address] = Mem_Write_Data;
    end

    // Observation word: {Busy, Done, Mem_Read, Mem_Write, Mem_Address, Mem_Write_Data}.
    assign obs = {Busy, Done, Mem_Read, Mem_Write, Mem_Address, Mem_Write_Data};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic drive_random();
        Start     = 1'($urandom_range(0, 1));
        Mode      = 1'($urandom_range(0, 1));
        Src_Addr  = 8'($urandom);
        Dst_Addr  = 8'($urandom);
        Length    = 8'($urandom);
        Fill_Data = 8'($urandom);
    endtask

    task automatic init_mem(input bit random_fill);
        for (int i = 0; i < 256; i++) begin
            mem[i]     = random_fill ? 8'($urandom) : 8'(i);
            exp_mem[i] = mem[i];
        end
    endtask

    task automatic check_mem(input string tag);
        int diffs;
        int first;
        diffs = 0;
        first = -1;
        for (int i = 0; i < 256; i++) begin
            if (mem[i] != exp_mem[i]) begin
                diffs++;
                if (first < 0) first = i;
            end
        end
        check($sformatf("%s_mem_diffs(first=%0d)", tag, first), diffs, 0);
    endtask

    // Reference model: forward byte copy / fill over the model memory,
    // producing the expected per-cycle port trace and the checksum.
    task automatic build_expect(input bit mode, input logic [7:0] src, input logic [7:0] dst,
                                input logic [7:0] len, input logic [7:0] fill);
        logic [7:0] a;
        logic [7:0] d;
        logic [7:0] v;
        exp_q.delete();
        exp_sum = 8'h00;
        for (int i = 0; i < int'(len); i++) begin
            a = 8'((int'(src) + i) % 256);
            d = 8'((int'(dst) + i) % 256);
            if (!mode) begin
                v = exp_mem[a];
                exp_q.push_back({1'b1, 1'b0, 1'b1, 1'b0, a, 8'h00});
            end else begin
                v = fill;
            end
            exp_q.push_back({1'b1, 1'b0, 1'b0, 1'b1, d, v});
            exp_mem[d] = v;
            exp_sum    = 8'((int'(exp_sum) + int'(v)) % 256);
        end
        exp_q.push_back({1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00});
    endtask

    // Call at a falling edge of an IDLE cycle; returns at a falling edge of an IDLE cycle.
    task automatic run_transfer(input string tag, input bit mode, input logic [7:0] src,
                                input logic [7:0] dst, input logic [7:0] len, input logic [7:0] fill);
        int n;
        build_expect(mode, src, dst, len, fill);
        Start     = 1'b1;
        Mode      = mode;
        Src_Addr  = src;
        Dst_Addr  = dst;
        Length    = len;
        Fill_Data = fill;
        @(posedge Clk);
        n = exp_q.size();
        for (int k = 0; k < n; k++) begin
            @(negedge Clk);
            check($sformatf("%s_cyc%0d", tag, k + 1), obs, exp_q[k]);
            drive_random();
        end
        check($sformatf("%s_csum", tag), Checksum, exp_sum);
        @(negedge Clk);
        check($sformatf("%s_idle", tag), obs, 20'h0);
        check($sformatf("%s_csum_hold", tag), Checksum, exp_sum);
        Start = 1'b0;
        check_mem(tag);
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Clear = 1'b0;
        drive_random();
        Start = 1'b1;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        check("rst_outputs", obs, 20'h0);
        check("rst_csum", Checksum, 8'h00);
        Clear = 1'b1;
        Start = 1'b0;
    endtask

    // Watchdog: a hung engine still ends the run with a report.
    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Clear = 1'b0;
        drive_random();
        do_reset();
        init_mem(1'b0);

        // Directed copy: bytes 2..5 into 20..23.
        run_transfer("copy", 1'b0, 8'd2, 8'd20, 8'd4, 8'h00);
        check("copy_csum_lit", Checksum, 8'h0E);
        check("copy_b23", mem[23], 8'h05);

        // Directed fill of 3 bytes with A5.
        run_transfer("fill", 1'b1, 8'd0, 8'd8, 8'd3, 8'hA5);
        check("fill_csum_lit", Checksum, 8'hEF);
        check("fill_b10", mem[10], 8'hA5);

        // Overlapping forward copy replicates byte 0.
        run_transfer("ovl", 1'b0, 8'd0, 8'd1, 8'd3, 8'h00);
        check("ovl_b1", mem[1], 8'h00);
        check("ovl_b3", mem[3], 8'h00);

        // Zero length: DONE immediately, no memory enables.
        run_transfer("len0", 1'b0, 8'd5, 8'd40, 8'd0, 8'h77);
        check("len0_csum_lit", Checksum, 8'h00);

        // Fill across the address wrap.
        run_transfer("wrap", 1'b1, 8'd0, 8'hFE, 8'd3, 8'h3C);
        check("wrap_b00", mem[0], 8'h3C);

        // Reset mid-transfer: Clear is sampled at the edge that would begin the
        // second write of a 4-byte copy, so exactly one byte lands.
        Start     = 1'b1;
        Mode      = 1'b0;
        Src_Addr  = 8'd100;
        Dst_Addr  = 8'd200;
        Length    = 8'd4;
        Fill_Data = 8'h00;
        @(posedge Clk);
        @(negedge Clk);
        check("mid_cyc1", obs, {1'b1, 1'b0, 1'b1, 1'b0, 8'd100, 8'h00});
        Start = 1'b0;
        @(negedge Clk);
        check("mid_cyc2", obs, {1'b1, 1'b0, 1'b0, 1'b1, 8'd200, exp_mem[100]});
        @(negedge Clk);
        check("mid_cyc3", obs, {1'b1, 1'b0, 1'b1, 1'b0, 8'd101, 8'h00});
        Clear = 1'b0;
        @(negedge Clk);
        check("mid_rst_outputs", obs, 20'h0);
        check("mid_rst_csum", Checksum, 8'h00);
        Clear = 1'b1;
        exp_mem[200] = exp_mem[100];
        check_mem("mid");
        run_transfer("post_rst", 1'b0, 8'd30, 8'd60, 8'd5, 8'h00);

        // Randomized transfers over a randomized memory image.
        init_mem(1'b1);
        for (int t = 0; t < 40; t++) begin
            logic [7:0] len;
            len = (t % 10 == 9) ? 8'($urandom_range(100, 255)) : 8'($urandom_range(0, 12));
            run_transfer($sformatf("rnd%0d", t), 1'($urandom_range(0, 1)),
                         8'($urandom), 8'($urandom), len, 8'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
